// File: rtl/spmp_csr_file_pkg.sv
// ---------------------------------------------------------------------------
// spmp_csr_file_pkg
// Shared types and constants for the S-mode SPMP CSR register file:
//   priv_lvl_t     privilege level of a CSR requester
//   spmpcfg_t      one 8-bit SPMP configuration byte (R, W, X, A, rsvd, S)
//   spmpaddr_t     stored address bits PLEN-1:2 (sized for the widest PLEN)
//   flush_state_t  state of the post-update flush handshake
//   CSR_*          CSR addresses of spmpcfg0, spmpaddr0 and spmpswitch
// ---------------------------------------------------------------------------
package spmp_csr_file_pkg;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_M = 2'b11
   } priv_lvl_t;

   // Output buses are always sized for the largest implementation.
   localparam int SPMP_N_ENTRIES = 64;
   // Widest supported physical address is 56 bits, stored without bits 1:0.
   localparam int SPMP_ADDR_W    = 54;

   typedef struct packed {
      logic       s;
      logic [1:0] rsvd;
      logic [1:0] a;
      logic       x;
      logic       w;
      logic       r;
   } spmpcfg_t;

   typedef logic [SPMP_ADDR_W-1:0] spmpaddr_t;

   localparam logic [11:0] CSR_SPMPCFG0   = 12'h1A0;
   localparam logic [11:0] CSR_SPMPADDR0  = 12'h1B0;
   localparam logic [11:0] CSR_SPMPSWITCH = 12'h170;

   typedef enum logic [0:0] {
      FLUSH_IDLE = 1'b0,
      FLUSH_WAIT = 1'b1
   } flush_state_t;

   // S=1 with XWR=000 is a reserved encoding that must never be stored.
   function automatic logic cfg_is_reserved(input spmpcfg_t cfg);
      return cfg.s && ({cfg.x, cfg.w, cfg.r} == 3'b000);
   endfunction

endpackage

// File: rtl/spmp_cfg_legalize.sv
// ---------------------------------------------------------------------------
// spmp_cfg_legalize
// WARL legalization of one spmpcfg byte.
//   old_cfg     currently stored byte for this entry
//   new_cfg     byte lane taken from the CSR write data
//   stored_cfg  value the entry holds after the write
// A reserved encoding leaves the entry untouched; otherwise the new byte is
// stored with its reserved field forced to zero.
// ---------------------------------------------------------------------------
module spmp_cfg_legalize
   import spmp_csr_file_pkg::*;
(
   input  spmpcfg_t old_cfg,
   input  spmpcfg_t new_cfg,
   output spmpcfg_t stored_cfg
);

   // Select between keeping the old byte and storing the cleaned new byte.
   always_comb begin
      stored_cfg = old_cfg;
      if (cfg_is_reserved(new_cfg)) begin
         stored_cfg = old_cfg;
      end else begin
         stored_cfg      = new_cfg;
         stored_cfg.rsvd = 2'b00;
      end
   end

endmodule

// File: rtl/spmp_csr_file.sv
// ---------------------------------------------------------------------------
// spmp_csr_file
// Owner of the S-mode SPMP CSR state (spmpcfg, spmpaddr, spmpswitch).
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   priv_lvl_i           privilege of the requesting instruction
//   req_valid_i/ready_o  request handshake (ready only while no flush pending)
//   req_we_i, req_addr_i, req_wdata_i   decoded CSR access
//   rsp_valid_o          one-cycle pulse the cycle after acceptance
//   rsp_rdata_o          read value (pre-write value for writes), 0 on error
//   rsp_err_o            unknown/unimplemented address or U-mode requester
//   spmpcfg_o, spmpaddr_o, spmpswitch_o  configuration for the checkers
//   flush_req_o/flush_ack_i  flush handshake after any effective change
// ---------------------------------------------------------------------------
module spmp_csr_file
   import spmp_csr_file_pkg::*;
#(
   parameter int PLEN       = 34,
   parameter int NR_ENTRIES = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  priv_lvl_t                     priv_lvl_i,
   input  logic                          req_valid_i,
   output logic                          req_ready_o,
   input  logic                          req_we_i,
   input  logic [11:0]                   req_addr_i,
   input  logic [63:0]                   req_wdata_i,
   output logic                          rsp_valid_o,
   output logic [63:0]                   rsp_rdata_o,
   output logic                          rsp_err_o,
   output spmpcfg_t  [SPMP_N_ENTRIES-1:0] spmpcfg_o,
   output spmpaddr_t [SPMP_N_ENTRIES-1:0] spmpaddr_o,
   output logic [63:0]                   spmpswitch_o,
   output logic                          flush_req_o,
   input  logic                          flush_ack_i
);

   localparam logic [31:0] NR_U = 32'(NR_ENTRIES);
   // Keeps only the PLEN-2 implemented address bits.
   localparam spmpaddr_t ADDR_MASK =
      {SPMP_ADDR_W{1'b1}} >> (SPMP_ADDR_W - (PLEN - 2));
   // Keeps only switch bits of implemented entries.
   localparam logic [63:0] SWITCH_MASK =
      (NR_ENTRIES >= 64) ? {64{1'b1}} : ((64'd1 << NR_ENTRIES) - 64'd1);

   flush_state_t state_r, state_next_s;

   spmpcfg_t  [SPMP_N_ENTRIES-1:0] cfg_r, cfg_next_s;
   spmpaddr_t [SPMP_N_ENTRIES-1:0] addr_r, addr_next_s;
   logic [63:0] switch_r, switch_next_s;

   logic        rsp_valid_r;
   logic        rsp_err_r;
   logic [63:0] rsp_rdata_r;

   logic        hit_cfg_s, hit_addr_s, hit_switch_s;
   logic        err_s, ready_s, flush_s, accept_s, wr_s, changed_s;
   logic [2:0]  cfg_sel_s;
   logic [5:0]  addr_sel_s;
   logic [63:0] rdata_s;

   // Address decode; entries at or beyond NR_ENTRIES count as unmapped.
   always_comb begin
      hit_cfg_s    = 1'b0;
      hit_addr_s   = 1'b0;
      cfg_sel_s    = req_addr_i[3:1];
      // spmpaddr0 sits at 0x1B0, so the low six bits minus 0x30 give n.
      addr_sel_s   = req_addr_i[5:0] - 6'h30;
      hit_switch_s = (req_addr_i == CSR_SPMPSWITCH);
      if ((req_addr_i[11:4] == CSR_SPMPCFG0[11:4]) && !req_addr_i[0]) begin
         hit_cfg_s = ({26'd0, cfg_sel_s, 3'b000} < NR_U);
      end else begin
         hit_cfg_s = 1'b0;
      end
      if ((req_addr_i >= CSR_SPMPADDR0) && (req_addr_i < 12'h1F0)) begin
         hit_addr_s = ({26'd0, addr_sel_s} < NR_U);
      end else begin
         hit_addr_s = 1'b0;
      end
      err_s = (priv_lvl_i == PRIV_LVL_U) ||
              !(hit_cfg_s || hit_addr_s || hit_switch_s);
   end

   assign accept_s = req_valid_i && ready_s;
   assign wr_s     = accept_s && req_we_i && !err_s;

   // Current-value read mux; also supplies the pre-write value for writes.
   always_comb begin
      rdata_s = 64'd0;
      if (hit_cfg_s) begin
         for (int b = 0; b < 8; b++) begin
            rdata_s[b*8 +: 8] = cfg_r[{cfg_sel_s, 3'(b)}];
         end
      end else if (hit_addr_s) begin
         rdata_s = 64'(addr_r[addr_sel_s]);
      end else if (hit_switch_s) begin
         rdata_s = switch_r;
      end else begin
         rdata_s = 64'd0;
      end
   end

   for (genvar e = 0; e < SPMP_N_ENTRIES; e++) begin : g_entry
      if (e < NR_ENTRIES) begin : g_impl
         spmpcfg_t wr_byte_s;
         spmpcfg_t legal_s;

         assign wr_byte_s = req_wdata_i[(e % 8) * 8 +: 8];

         spmp_cfg_legalize u_legalize (
            .old_cfg   (cfg_r[e]),
            .new_cfg   (wr_byte_s),
            .stored_cfg(legal_s)
         );

         assign cfg_next_s[e]  = (wr_s && hit_cfg_s && (cfg_sel_s == 3'(e / 8)))
                                 ? legal_s : cfg_r[e];
         assign addr_next_s[e] = (wr_s && hit_addr_s && (addr_sel_s == 6'(e)))
                                 ? (req_wdata_i[SPMP_ADDR_W-1:0] & ADDR_MASK)
                                 : addr_r[e];
      end else begin : g_unimpl
         assign cfg_next_s[e]  = '0;
         assign addr_next_s[e] = '0;
      end
   end

   assign switch_next_s = (wr_s && hit_switch_s)
                          ? (req_wdata_i & SWITCH_MASK) : switch_r;

   // Only a write that alters stored state needs the consumers flushed.
   assign changed_s = (cfg_next_s != cfg_r) || (addr_next_s != addr_r) ||
                      (switch_next_s != switch_r);

   // Configuration state registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cfg_r    <= '0;
         addr_r   <= '0;
         switch_r <= 64'd0;
      end else begin
         cfg_r    <= cfg_next_s;
         addr_r   <= addr_next_s;
         switch_r <= switch_next_s;
      end
   end

   // Response registers: one-cycle pulse following each accepted request.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
         rsp_rdata_r <= 64'd0;
      end else begin
         rsp_valid_r <= accept_s;
         rsp_err_r   <= accept_s && err_s;
         rsp_rdata_r <= (accept_s && !err_s) ? rdata_s : 64'd0;
      end
   end

   // Flush FSM state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r <= FLUSH_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Flush FSM next-state logic; an ack while idle has no effect.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         FLUSH_IDLE: begin
            if (wr_s && changed_s) begin
               state_next_s = FLUSH_WAIT;
            end else begin
               state_next_s = FLUSH_IDLE;
            end
         end
         FLUSH_WAIT: begin
            if (flush_ack_i) begin
               state_next_s = FLUSH_IDLE;
            end else begin
               state_next_s = FLUSH_WAIT;
            end
         end
         default: state_next_s = FLUSH_IDLE;
      endcase
   end

   // Flush FSM outputs, decoded from the registered state only.
   always_comb begin
      ready_s = 1'b1;
      flush_s = 1'b0;
      case (state_r)
         FLUSH_IDLE: begin
            ready_s = 1'b1;
            flush_s = 1'b0;
         end
         FLUSH_WAIT: begin
            ready_s = 1'b0;
            flush_s = 1'b1;
         end
         default: begin
            ready_s = 1'b1;
            flush_s = 1'b0;
         end
      endcase
   end

   assign req_ready_o  = ready_s;
   assign flush_req_o  = flush_s;
   assign rsp_valid_o  = rsp_valid_r;
   assign rsp_err_o    = rsp_err_r;
   assign rsp_rdata_o  = rsp_rdata_r;
   assign spmpcfg_o    = cfg_r;
   assign spmpaddr_o   = addr_r;
   assign spmpswitch_o = switch_r;

endmodule

// File: tb/tb_spmp_csr_file.sv
// ---------------------------------------------------------------------------
// tb_spmp_csr_file
// Directed bench for spmp_csr_file (PLEN=34, NR_ENTRIES=16) with
// hand-computed expected values.
// ---------------------------------------------------------------------------
module tb_spmp_csr_file;
   import spmp_csr_file_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   priv_lvl_t   priv_lvl_i;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [11:0] req_addr_i;
   logic [63:0] req_wdata_i;
   logic        rsp_valid_o;
   logic [63:0] rsp_rdata_o;
   logic        rsp_err_o;
   spmpcfg_t  [SPMP_N_ENTRIES-1:0] spmpcfg_o;
   spmpaddr_t [SPMP_N_ENTRIES-1:0] spmpaddr_o;
   logic [63:0] spmpswitch_o;
   logic        flush_req_o;
   logic        flush_ack_i;

   int n_checks = 0;
   int n_pass   = 0;

   spmp_csr_file #(.PLEN(34), .NR_ENTRIES(16)) dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .priv_lvl_i  (priv_lvl_i),
      .req_valid_i (req_valid_i),
      .req_ready_o (req_ready_o),
      .req_we_i    (req_we_i),
      .req_addr_i  (req_addr_i),
      .req_wdata_i (req_wdata_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_rdata_o (rsp_rdata_o),
      .rsp_err_o   (rsp_err_o),
      .spmpcfg_o   (spmpcfg_o),
      .spmpaddr_o  (spmpaddr_o),
      .spmpswitch_o(spmpswitch_o),
      .flush_req_o (flush_req_o),
      .flush_ack_i (flush_ack_i)
   );

   // Free-running clock.
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one request; returns #1 after the accepting edge (cycle t+1).
   task automatic csr_req(input priv_lvl_t p, input logic we, input logic [11:0] a,
                          input logic [63:0] d);
      @(negedge clk_i);
      priv_lvl_i  = p;
      req_we_i    = we;
      req_addr_i  = a;
      req_wdata_i = d;
      req_valid_i = 1'b1;
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
   endtask

   // Response check at t+1, then confirm the pulse is gone at t+2.
   task automatic check_rsp(input string tag, input logic [63:0] rdata, input logic err);
      check({tag, "_valid"}, 64'(rsp_valid_o), 64'd1);
      check({tag, "_rdata"}, rsp_rdata_o, rdata);
      check({tag, "_err"}, 64'(rsp_err_o), 64'(err));
   endtask

   task automatic check_pulse_end(input string tag);
      @(posedge clk_i);
      #1;
      check({tag, "_pulse_end"}, 64'(rsp_valid_o), 64'd0);
   endtask

   // Called at t+1 of a flushing write: ack sampled at end of t+3, idle at t+4.
   task automatic run_flush(input string tag);
      check({tag, "_flush_rise"}, 64'(flush_req_o), 64'd1);
      check({tag, "_ready_fall"}, 64'(req_ready_o), 64'd0);
      @(posedge clk_i);
      #1;
      check({tag, "_flush_hold"}, 64'(flush_req_o), 64'd1);
      @(posedge clk_i);
      #1;
      flush_ack_i = 1'b1;
      @(posedge clk_i);
      #1;
      flush_ack_i = 1'b0;
      check({tag, "_flush_drop"}, 64'(flush_req_o), 64'd0);
      check({tag, "_ready_back"}, 64'(req_ready_o), 64'd1);
   endtask

   task automatic read_chk(input string tag, input priv_lvl_t p, input logic [11:0] a,
                           input logic [63:0] rdata, input logic err);
      csr_req(p, 1'b0, a, 64'd0);
      check_rsp(tag, rdata, err);
      check({tag, "_noflush"}, 64'(flush_req_o), 64'd0);
      check_pulse_end(tag);
   endtask

   initial begin
      rst_ni      = 1'b0;
      priv_lvl_i  = PRIV_LVL_S;
      req_valid_i = 1'b0;
      req_we_i    = 1'b0;
      req_addr_i  = 12'h000;
      req_wdata_i = 64'd0;
      flush_ack_i = 1'b0;
      #12;
      check("rst_ready", 64'(req_ready_o), 64'd1);
      check("rst_flush", 64'(flush_req_o), 64'd0);
      check("rst_valid", 64'(rsp_valid_o), 64'd0);
      check("rst_rdata", rsp_rdata_o, 64'd0);
      check("rst_err", 64'(rsp_err_o), 64'd0);
      check("rst_cfg", 64'(|spmpcfg_o), 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      // Reset read of spmpcfg0.
      read_chk("rd_cfg0_rst", PRIV_LVL_S, 12'h1A0, 64'd0, 1'b0);

      // Ack while idle must be ignored.
      @(negedge clk_i);
      flush_ack_i = 1'b1;
      @(negedge clk_i);
      flush_ack_i = 1'b0;
      check("idle_ack_ignored", 64'(flush_req_o), 64'd0);

      // Entry0 0x67 -> 0x07 (rsvd cleared), entry1 0x8F legal.
      csr_req(PRIV_LVL_S, 1'b1, 12'h1A0, 64'h0000_0000_0000_8F67);
      check_rsp("wr_cfg0", 64'd0, 1'b0);
      check("cfg_e0", 64'(spmpcfg_o[0]), 64'h07);
      check("cfg_e1", 64'(spmpcfg_o[1]), 64'h8F);
      run_flush("wr_cfg0");
      read_chk("rd_cfg0", PRIV_LVL_S, 12'h1A0, 64'h8F07, 1'b0);

      // Give entry2 a value, then try the reserved encoding on it.
      csr_req(PRIV_LVL_S, 1'b1, 12'h1A0, 64'h0000_0000_0001_8F07);
      check_rsp("wr_e2", 64'h8F07, 1'b0);
      run_flush("wr_e2");
      csr_req(PRIV_LVL_S, 1'b1, 12'h1A0, 64'h0000_0000_0080_8F07);
      check_rsp("wr_e2_rsvd", 64'h0001_8F07, 1'b0);
      check("e2_rsvd_kept", 64'(spmpcfg_o[2]), 64'h01);
      check("e2_rsvd_noflush", 64'(flush_req_o), 64'd0);
      check("e2_rsvd_ready", 64'(req_ready_o), 64'd1);
      read_chk("rd_cfg0_rsvd", PRIV_LVL_S, 12'h1A0, 64'h0001_8F07, 1'b0);

      // spmpaddr3 all ones: only 32 bits implemented for PLEN=34.
      csr_req(PRIV_LVL_S, 1'b1, 12'h1B3, {64{1'b1}});
      check_rsp("wr_addr3", 64'd0, 1'b0);
      check("addr3_out", 64'(spmpaddr_o[3]), 64'h0000_0000_FFFF_FFFF);
      run_flush("wr_addr3");
      read_chk("rd_addr3", PRIV_LVL_S, 12'h1B3, 64'h0000_0000_FFFF_FFFF, 1'b0);

      // Errors: U-mode write, odd cfg address, entry beyond NR_ENTRIES.
      csr_req(PRIV_LVL_U, 1'b1, 12'h170, {64{1'b1}});
      check_rsp("u_wr_switch", 64'd0, 1'b1);
      check("u_wr_noflush", 64'(flush_req_o), 64'd0);
      check("u_wr_switch_kept", spmpswitch_o, 64'd0);
      check_pulse_end("u_wr_switch");
      read_chk("rd_cfg1_odd", PRIV_LVL_S, 12'h1A1, 64'd0, 1'b1);
      read_chk("rd_addr16", PRIV_LVL_S, 12'h1C0, 64'd0, 1'b1);
      read_chk("rd_cfg4", PRIV_LVL_S, 12'h1A4, 64'd0, 1'b1);
      csr_req(PRIV_LVL_S, 1'b1, 12'h1A1, {64{1'b1}});
      check_rsp("wr_cfg1_odd", 64'd0, 1'b1);
      check("odd_wr_noflush", 64'(flush_req_o), 64'd0);
      check("odd_wr_e0_kept", 64'(spmpcfg_o[0]), 64'h07);
      read_chk("rd_cfg2", PRIV_LVL_S, 12'h1A2, 64'd0, 1'b0);

      // spmpswitch: only bits of the 16 implemented entries stick.
      csr_req(PRIV_LVL_S, 1'b1, 12'h170, {64{1'b1}});
      check_rsp("wr_switch", 64'd0, 1'b0);
      check("switch_out", spmpswitch_o, 64'h0000_0000_0000_FFFF);
      run_flush("wr_switch");
      read_chk("rd_switch_m", PRIV_LVL_M, 12'h170, 64'h0000_0000_0000_FFFF, 1'b0);

      // Reset while flushing clears everything at once.
      csr_req(PRIV_LVL_S, 1'b1, 12'h1B0, 64'd5);
      check("addr0_out", 64'(spmpaddr_o[0]), 64'd5);
      check("pre_rst_flush", 64'(flush_req_o), 64'd1);
      rst_ni = 1'b0;
      #1;
      check("rst_flush_drop", 64'(flush_req_o), 64'd0);
      check("rst_valid_drop", 64'(rsp_valid_o), 64'd0);
      check("rst_cfg_clear", 64'(|spmpcfg_o), 64'd0);
      check("rst_addr_clear", 64'(|spmpaddr_o), 64'd0);
      check("rst_switch_clear", spmpswitch_o, 64'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      check("post_rst_ready", 64'(req_ready_o), 64'd1);
      check("post_rst_flush", 64'(flush_req_o), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
